// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and types for the multi-channel clock-enable divider.
//   CNT_W_DEF    - default counter/divisor width per channel
//   DEF_DIV_DEF  - default reset divisor (tick period 2**26 advances)
//   NCH_DEF      - default channel count
//   cnt_t        - counter/divisor type at the default width
//   ch_idx_t     - channel index type at the default channel count
//   ch_w()       - channel-select width for a given channel count (minimum 1)
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF   = 27;
    localparam int unsigned DEF_DIV_DEF = 2**26 - 1;
    localparam int unsigned NCH_DEF     = 4;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [CNT_W_DEF-1:0]        cnt_t;
    typedef logic [ch_w(NCH_DEF)-1:0]    ch_idx_t;

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with glitch-free runtime divisor update.
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   en_i     - global enable (a write while disabled applies immediately)
//   adv_i    - advance this channel's counter this cycle
//   clr_i    - synchronous phase clear; applies any pending divisor
//   wr_i     - divisor write strobe for this channel
//   val_i    - divisor value to write
//   at_top_o - counter currently equals the active divisor (unqualified by adv)
//   tick_o   - registered one-cycle terminal-count pulse
//   sq_o     - registered square wave, toggles on each terminal count
//   pend_o   - a written divisor is waiting for the next terminal count
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             adv_i,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             at_top_o,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pend_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             sq_q, sq_d;
    logic             tick_q, tick_d;
    logic             term;

    assign at_top_o = (cnt_q == act_q);
    assign term     = adv_i & at_top_o;

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d  = '0;
            sq_d   = 1'b0;
            pend_d = 1'b0;
            if (wr_i) begin
                act_d = val_i;
            end else if (pend_q) begin
                act_d = pdiv_q;
            end
        end else begin
            if (term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else if (adv_i) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Divisor only changes at a period boundary, unless the channel is
            // idle (en low) where there is no running period to corrupt.
            if (wr_i && (!en_i || term)) begin
                act_d  = val_i;
                pend_d = 1'b0;
            end else if (term && pend_q) begin
                act_d  = pdiv_q;
                pend_d = 1'b0;
            end else if (wr_i) begin
                pdiv_d = val_i;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            act_q  <= DEF_DIV;
            pdiv_q <= DEF_DIV;
            pend_q <= 1'b0;
            sq_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            sq_q   <= sq_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH-channel synchronous programmable clock-enable divider.
//   clk     - system clock, rising edge
//   rst     - asynchronous active-low reset
//   en      - global count enable
//   clr     - synchronous phase clear of all channels
//   div_wr  - divisor write strobe
//   div_ch  - target channel of the write (out-of-range writes are ignored)
//   div_val - new divisor D (tick period D+1 advances)
//   tick_o  - per-channel one-cycle terminal-count pulse
//   sq_o    - per-channel 50% square wave
//   pend_o  - per-channel divisor-write-pending flag
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned      NCH     = NCH_DEF,
    parameter int unsigned      CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_DEF),
    parameter int unsigned      CASCADE = 0,
    localparam int unsigned     CH_W    = ch_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             div_wr,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [CNT_W-1:0] div_val,
    output logic [NCH-1:0]   tick_o,
    output logic [NCH-1:0]   sq_o,
    output logic [NCH-1:0]   pend_o
);

    logic [NCH-1:0] adv;
    logic [NCH-1:0] at_top;
    logic [NCH-1:0] wr;

    // In cascade mode channel i advances when every lower channel is at its
    // terminal count this cycle; that prefix-AND equals "channel i-1 ticks now"
    // but depends only on counter state, so the chain has no feedback through adv.
    always_comb begin
        logic run;
        run = 1'b1;
        adv = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            adv[i] = en & ((CASCADE == 0) | run);
            run    = run & at_top[i];
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr[i] = div_wr & (div_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en_i     (en),
            .adv_i    (adv[i]),
            .clr_i    (clr),
            .wr_i     (wr[i]),
            .val_i    (div_val),
            .at_top_o (at_top[i]),
            .tick_o   (tick_o[i]),
            .sq_o     (sq_o[i]),
            .pend_o   (pend_o[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // u0: NCH=2, CNT_W=4, DEF_DIV=3, independent channels
    logic       en0 = 1'b1, clr0 = 1'b0, wr0 = 1'b0;
    logic [0:0] ch0 = 1'b0;
    logic [3:0] val0 = 4'd0;
    logic [1:0] tick0, sq0, pend0;

    // u1: NCH=3, CNT_W=4, DEF_DIV=1, cascaded
    logic       en1 = 1'b0, clr1 = 1'b0, wr1 = 1'b0;
    logic [1:0] ch1 = 2'd0;
    logic [3:0] val1 = 4'd0;
    logic [2:0] tick1, sq1, pend1;

    int vectors = 0;
    int miscompares = 0;

    clk_div_multi #(.NCH(2), .CNT_W(4), .DEF_DIV(4'd3), .CASCADE(0)) u0 (
        .clk(clk), .rst(rst), .en(en0), .clr(clr0), .div_wr(wr0),
        .div_ch(ch0), .div_val(val0), .tick_o(tick0), .sq_o(sq0), .pend_o(pend0)
    );

    clk_div_multi #(.NCH(3), .CNT_W(4), .DEF_DIV(4'd1), .CASCADE(1)) u1 (
        .clk(clk), .rst(rst), .en(en1), .clr(clr1), .div_wr(wr1),
        .div_ch(ch1), .div_val(val1), .tick_o(tick1), .sq_o(sq1), .pend_o(pend1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Outputs cleared while reset held
        step();
        chk("rst_tick", 32'(tick0), 32'd0);
        chk("rst_sq",   32'(sq0),   32'd0);
        chk("rst_pend", 32'(pend0), 32'd0);
        step();
        rst = 1'b1;

        // Default divisor 3: ticks at cycles 4, 8, 12; sq toggles on each
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("def_tick", 32'(tick0), 32'({2{k % 4 == 0}}));
            chk("def_sq",   32'(sq0),   32'({2{(k / 4) % 2 == 1}}));
        end

        // Glitch-free write: D=1 to ch0 while cnt=1
        step();
        chk("gf_tick13", 32'(tick0), 32'd0);
        wr0 = 1'b1; ch0 = 1'b0; val0 = 4'd1;
        step();
        wr0 = 1'b0;
        chk("gf_pend", 32'(pend0), 32'b01);
        step();
        chk("gf_tick15", 32'(tick0), 32'd0);
        chk("gf_pend15", 32'(pend0), 32'b01);
        step();
        chk("gf_tick16", 32'(tick0), 32'b11);
        chk("gf_pend16", 32'(pend0), 32'd0);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("gf_run", 32'(tick0), 32'({j == 4, j % 2 == 0}));
        end

        // Enable low for 5 cycles: hold counters and sq
        en0 = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step();
            chk("hold_tick", 32'(tick0), 32'd0);
            chk("hold_sq",   32'(sq0),   32'b11);
        end
        en0 = 1'b1;
        step();
        chk("resume1", 32'(tick0), 32'd0);
        step();
        chk("resume2", 32'(tick0), 32'b11);
        chk("resume_sq", 32'(sq0), 32'd0);
        step();
        // Pending write to ch1, then clear applies it immediately
        wr0 = 1'b1; ch0 = 1'b1; val0 = 4'd2;
        step();
        wr0 = 1'b0;
        chk("pre_clr_pend", 32'(pend0), 32'b10);
        chk("pre_clr_sq",   32'(sq0),   32'b01);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        chk("clr_sq",   32'(sq0),   32'd0);
        chk("clr_tick", 32'(tick0), 32'd0);
        chk("clr_pend", 32'(pend0), 32'd0);
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("post_clr", 32'(tick0), 32'({j % 3 == 0, j % 2 == 0}));
        end

        // D=0 written while disabled: applies at once, tick every cycle
        en0 = 1'b0; wr0 = 1'b1; ch0 = 1'b0; val0 = 4'd0;
        step();
        wr0 = 1'b0; en0 = 1'b1;
        chk("d0_pend", 32'(pend0), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("d0_tick", 32'(tick0), 32'({k % 3 == 0, 1'b1}));
            chk("d0_sq",   32'(sq0[0]), 32'(k % 2 == 0));
        end

        // D=15 (max) written with clear: period 16, no overflow
        clr0 = 1'b1; wr0 = 1'b1; ch0 = 1'b0; val0 = 4'd15;
        step();
        clr0 = 1'b0; wr0 = 1'b0;
        chk("d15_clr_sq", 32'(sq0), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("d15_tick", 32'(tick0), 32'({k % 3 == 0, k == 16}));
            chk("d15_sq",   32'(sq0[0]), 32'(k >= 16));
        end

        // Write coinciding with ch1 terminal: D=0 used from the next period
        step();
        chk("tw_tick17", 32'(tick0), 32'd0);
        wr0 = 1'b1; ch0 = 1'b1; val0 = 4'd0;
        step();
        wr0 = 1'b0;
        chk("tw_tick18", 32'(tick0), 32'b10);
        chk("tw_pend",   32'(pend0), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("tw_run", 32'(tick0), 32'b10);
        end

        // Async reset mid-operation with a pending write
        wr0 = 1'b1; ch0 = 1'b0; val0 = 4'd5;
        step();
        wr0 = 1'b0;
        chk("ar_pend_set", 32'(pend0), 32'b01);
        #3 rst = 1'b0;
        #1;
        chk("ar_tick", 32'(tick0), 32'd0);
        chk("ar_sq",   32'(sq0),   32'd0);
        chk("ar_pend", 32'(pend0), 32'd0);
        step();
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("ar_def_tick", 32'(tick0), 32'({2{k % 4 == 0}}));
            chk("ar_def_pend", 32'(pend0), 32'd0);
        end

        // Cascade, all D=1: sq periods 4, 8, 16; out-of-range write ignored
        en1 = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) begin
                wr1 = 1'b1; ch1 = 2'd3; val1 = 4'd0;
            end else begin
                wr1 = 1'b0;
            end
            step();
            chk("cas_sq",   32'(sq1),
                32'({(k / 8) % 2 == 1, (k / 4) % 2 == 1, (k / 2) % 2 == 1}));
            chk("cas_tick", 32'(tick1),
                32'({k % 8 == 0, k % 4 == 0, k % 2 == 0}));
            chk("cas_pend", 32'(pend1), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
